// File: rtl/adder_pkg.sv
// Shared definitions for the sequential chunk adder: FSM states, default
// geometry and the parameter sanity check used at elaboration.
package adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when CHUNK evenly tiles WIDTH with at least one bit per chunk.
    function automatic bit width_ok(input int w, input int c);
        return (c >= 1) && (c <= w) && ((w % c) == 0);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Purely combinational CHUNK-bit ripple-carry adder; the only arithmetic
// in the sequential adder, so it bounds the critical path.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    output logic             co,
    output logic [CHUNK-1:0] s,
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci
);

    logic [CHUNK:0] w_c;

    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]     = x[i] ^ y[i] ^ w_c[i];
            w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
        end
    end

    assign co = w_c[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: one CHUNK-wide slice per clock, carry held in
// a register between slices, valid/ready handshakes on both sides.
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int MSB    = WIDTH - 1;

    generate
        if (!width_ok(WIDTH, CHUNK)) begin : g_bad_geometry
            $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cy;
    logic [IDXW-1:0]   r_idx;

    int                w_base;
    logic              w_last;
    logic [CHUNK-1:0]  w_x;
    logic [CHUNK-1:0]  w_y;
    logic [CHUNK-1:0]  w_s;
    logic              w_co;

    assign w_base = int'(r_idx) * CHUNK;
    assign w_last = (r_idx == IDXW'(NCHUNK - 1));
    assign w_x    = r_a[w_base +: CHUNK];
    assign w_y    = r_b[w_base +: CHUNK];

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .co (w_co),
        .s  (w_s),
        .x  (w_x),
        .y  (w_y),
        .ci (r_cy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: invert B at capture and seed the carry with sub.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sum <= '0;
            r_cy  <= 1'b0;
            r_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b ^ {WIDTH{sub}};
                        r_sum <= '0;
                        r_cy  <= sub;
                        r_idx <= '0;
                    end
                end
                RUN: begin
                    r_sum[w_base +: CHUNK] <= w_s;
                    r_cy                   <= w_co;
                    r_idx                  <= r_idx + IDXW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        busy      = (r_state == RUN);
        out_valid = (r_state == DONE);
        sum       = '0;
        c_out     = 1'b0;
        ovf       = 1'b0;
        if (r_state == DONE) begin
            sum   = r_sum;
            c_out = r_cy;
            ovf   = (r_a[MSB] == r_b[MSB]) && (r_sum[MSB] != r_a[MSB]);
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder at WIDTH=16, CHUNK=4: directed
// cases, backpressure, input scrambling during RUN, mid-RUN reset, random ops.
module tb_seq_chunk_adder;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             busy;

    int total = 0;
    int bad   = 0;

    seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on the original operands.
    task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic msub,
                         output logic [WIDTH-1:0] es, output logic ec, output logic eo);
        int sa, sb, r;
        int ua, ub;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        ua = int'(ma);
        ub = int'(mb);
        r  = msub ? (sa - sb) : (sa + sb);
        es = WIDTH'(msub ? (ua - ub) : (ua + ub));
        ec = msub ? (ua >= ub) : ((ua + ub) > 65535);
        eo = (r > 32767) || (r < -32768);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic osub,
                          input int hold, input bit scramble);
        logic [WIDTH-1:0] es;
        logic             ec, eo;
        int               lat;
        model(oa, ob, osub, es, ec, eo);
        @(negedge clk);
        in_valid  = 1'b1;
        a         = oa;
        b         = ob;
        sub       = osub;
        out_ready = 1'b0;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            check("in_ready_low_in_run", 32'(in_ready), 32'd0);
            check("busy_in_run", 32'(busy), 32'd1);
            if (scramble) begin
                in_valid = 1'($urandom_range(0, 1));
                a        = WIDTH'($urandom);
                b        = WIDTH'($urandom);
                sub      = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("latency", 32'(lat), 32'(NCHUNK));
        check("busy_in_done", 32'(busy), 32'd0);
        check("sum", 32'(sum), 32'(es));
        check("c_out", 32'(c_out), 32'(ec));
        check("ovf", 32'(ovf), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            if (scramble) begin
                a   = WIDTH'($urandom);
                b   = WIDTH'($urandom);
                sub = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_sum", 32'(sum), 32'(es));
            check("hold_c_out", 32'(c_out), 32'(ec));
            check("hold_ovf", 32'(ovf), 32'(eo));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_take", 32'(out_valid), 32'd0);
        check("in_ready_after_take", 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_sum"},       32'(sum),       32'd0);
        check({tag, "_c_out"},     32'(c_out),     32'd0);
        check({tag, "_ovf"},       32'(ovf),       32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        sub       = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        run_op(16'h1234, 16'h0FCD, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 0, 1'b0);
        run_op(16'h0003, 16'h0005, 1'b1, 0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 5, 1'b1);
        run_op(16'hA5A5, 16'h5A5B, 1'b1, 2, 1'b1);

        // Reset asserted in the second RUN cycle discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'h4321;
        b        = 16'h1111;
        sub      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_run_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_reset");
        run_op(16'h0001, 16'h0002, 1'b0, 0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
